// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send handshake, 11-bit frame, device ACK check.
// Drives the open-drain keyboard pads through active-high pull-low controls only.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       edge_found,
    input  logic       kb_data_sync,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic       kb_clk_drive_low,
    output logic       kb_data_drive_low
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        REQ     = 3'd2,
        SEND    = 3'd3,
        ACK     = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [8:0]        shift_reg, shift_next;
    logic [3:0]        bit_cnt_reg, bit_cnt_next;
    logic [INH_W-1:0]  inh_cnt_reg, inh_cnt_next;
    logic [WD_W-1:0]   wdog_reg, wdog_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              error_reg, error_next;
    logic              clk_low_reg, clk_low_next;
    logic              data_low_reg, data_low_next;
    logic              wdog_expired;

    assign wdog_expired = (wdog_reg >= WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            inh_cnt_reg  <= '0;
            wdog_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            clk_low_reg  <= 1'b0;
            data_low_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            inh_cnt_reg  <= inh_cnt_next;
            wdog_reg     <= wdog_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
            clk_low_reg  <= clk_low_next;
            data_low_reg <= data_low_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        inh_cnt_next  = inh_cnt_reg;
        wdog_next     = wdog_reg;
        data_low_next = data_low_reg;
        done_next     = 1'b0;
        error_next    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                data_low_next = 1'b0;
                if (tx_start) begin
                    shift_next   = {~^tx_data, tx_data};
                    bit_cnt_next = '0;
                    inh_cnt_next = '0;
                    state_next   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_reg >= INH_LAST) begin
                    data_low_next = 1'b1;
                    state_next    = REQ;
                end else begin
                    inh_cnt_next = inh_cnt_reg + 1'b1;
                end
            end
            REQ: begin
                wdog_next  = '0;
                state_next = SEND;
            end
            SEND, ACK: begin
                if (wdog_reg != '1) begin
                    wdog_next = wdog_reg + 1'b1;
                end
                if (edge_found) begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (state_reg == ACK) begin
                        // Device pulls data low to acknowledge on the 11th falling edge.
                        done_next  = ~kb_data_sync;
                        error_next = kb_data_sync;
                        state_next = DONE;
                    end else if (bit_cnt_reg < 4'd9) begin
                        data_low_next = ~shift_reg[0];
                        shift_next    = {1'b0, shift_reg[8:1]};
                    end else begin
                        data_low_next = 1'b0;
                        state_next    = ACK;
                    end
                end else if (wdog_expired) begin
                    data_low_next = 1'b0;
                    error_next    = 1'b1;
                    state_next    = IDLE;
                end
            end
            DONE: begin
                data_low_next = 1'b0;
                state_next    = IDLE;
            end
            default: begin
                data_low_next = 1'b0;
                state_next    = IDLE;
            end
        endcase

        clk_low_next = (state_next == INHIBIT) || (state_next == REQ);
        busy_next    = (state_next != IDLE);
    end

    assign tx_busy           = busy_reg;
    assign tx_done           = done_reg;
    assign tx_error          = error_reg;
    assign kb_clk_drive_low  = clk_low_reg;
    assign kb_data_drive_low = data_low_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: table of command bytes driven through a model PS/2 device,
// with expected data-line levels and outcomes held in scoreboard queues.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       edge_found = 1'b0;
    logic       kb_data_sync = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy, tx_done, tx_error, kb_clk_drive_low, kb_data_drive_low;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    logic       exp_q[$];
    logic [1:0] out_q[$];

    typedef struct {
        logic [7:0] data;
        logic       parity;
        logic       ack;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(500)) dut (
        .clk              (clk),
        .rst              (rst),
        .edge_found       (edge_found),
        .kb_data_sync     (kb_data_sync),
        .tx_start         (tx_start),
        .tx_data          (tx_data),
        .tx_busy          (tx_busy),
        .tx_done          (tx_done),
        .tx_error         (tx_error),
        .kb_clk_drive_low (kb_clk_drive_low),
        .kb_data_drive_low(kb_data_drive_low)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done)  done_cnt++;
        if (tx_error) err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    task automatic run_tx(input logic [7:0] d, input logic par, input logic ack,
                          input logic exp_done, input logic exp_err,
                          input int intrude_at, input int reset_at);
        int n;
        int done_before;
        int err_before;
        logic e;
        logic [1:0] o;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(~d[i]);
        exp_q.push_back(~par);
        exp_q.push_back(1'b0);
        if (reset_at == 0) out_q.push_back({exp_done, exp_err});
        done_before = done_cnt;
        err_before  = err_cnt;

        @(posedge clk); #1 tx_start = 1'b1; tx_data = d;
        @(posedge clk); #1 tx_start = 1'b0; tx_data = ~d;
        @(negedge clk);
        check("busy_after_accept", tx_busy, 1'b1);
        n = 0;
        while (kb_clk_drive_low && !kb_data_drive_low && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, 20);
        check("req_clk_low", kb_clk_drive_low, 1'b1);
        check("req_data_low", kb_data_drive_low, 1'b1);
        @(negedge clk);
        check("send_clk_released", kb_clk_drive_low, 1'b0);
        check("start_bit_low", kb_data_drive_low, 1'b1);

        for (int k = 1; k <= 11; k++) begin
            if (k == intrude_at) begin
                @(posedge clk); #1 tx_start = 1'b1; tx_data = 8'h55;
                @(posedge clk); #1 tx_start = 1'b0;
            end
            repeat (2) @(posedge clk);
            #1 edge_found = 1'b1;
            if (k == 11) kb_data_sync = ack;
            @(posedge clk);
            #1 edge_found = 1'b0;
            kb_data_sync = 1'b1;
            @(negedge clk);
            if (k <= 10) begin
                e = exp_q.pop_front();
                check($sformatf("data_after_edge%0d", k), kb_data_drive_low, e);
            end
            if (k == reset_at) begin
                #1 rst = 1'b0;
                #1;
                check("rst_clk_low", kb_clk_drive_low, 1'b0);
                check("rst_data_low", kb_data_drive_low, 1'b0);
                check("rst_busy", tx_busy, 1'b0);
                repeat (3) @(negedge clk);
                check("rst_no_pulse", {done_cnt - done_before, err_cnt - err_before}, 0);
                @(posedge clk); #2 rst = 1'b1;
                return;
            end
            if (k == 11) begin
                o = out_q.pop_front();
                check("done_pulse", tx_done, o[1]);
                check("error_pulse", tx_error, o[0]);
                check("busy_in_done", tx_busy, 1'b1);
                @(negedge clk);
                check("end_pulses_clear", {tx_done, tx_error}, 2'b00);
                check("end_busy", tx_busy, 1'b0);
                check("end_lines", {kb_clk_drive_low, kb_data_drive_low}, 2'b00);
                check("done_count", done_cnt - done_before, {31'd0, o[1]});
                check("error_count", err_cnt - err_before, {31'd0, o[0]});
            end
        end
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{data: 8'hED, parity: 1'b1, ack: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{data: 8'h01, parity: 1'b0, ack: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[2] = '{data: 8'hFF, parity: 1'b1, ack: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[3] = '{data: 8'h00, parity: 1'b1, ack: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[4] = '{data: 8'h3C, parity: 1'b1, ack: 1'b1, exp_done: 1'b0, exp_err: 1'b1};

        repeat (3) @(negedge clk);
        check("reset_outputs", {tx_busy, tx_done, tx_error, kb_clk_drive_low, kb_data_drive_low}, 5'b0);
        @(posedge clk); #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", {tx_busy, kb_clk_drive_low, kb_data_drive_low}, 3'b0);

        for (int v = 0; v < 5; v++) begin
            $display("[TB] vector %0d: data=%02h ack=%0d", v, vecs[v].data, vecs[v].ack);
            run_tx(vecs[v].data, vecs[v].parity, vecs[v].ack, vecs[v].exp_done, vecs[v].exp_err, 0, 0);
        end

        $display("[TB] watchdog: device never clocks");
        @(posedge clk); #1 tx_start = 1'b1; tx_data = 8'hED;
        @(posedge clk); #1 tx_start = 1'b0;
        @(negedge clk);
        n = 0;
        while (kb_clk_drive_low && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("wd_clk_released", kb_clk_drive_low, 1'b0);
        n = 0;
        while (!tx_error && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wd_latency", n, 500);
        check("wd_lines", {kb_clk_drive_low, kb_data_drive_low}, 2'b00);
        check("wd_busy", tx_busy, 1'b0);
        @(negedge clk);
        check("wd_error_one_cycle", tx_error, 1'b0);

        $display("[TB] tx_start 0x55 during 0xED transfer");
        n = done_cnt;
        run_tx(8'hED, 1'b1, 1'b0, 1'b1, 1'b0, 4, 0);
        repeat (30) @(negedge clk);
        check("intrude_no_restart", {tx_busy, kb_clk_drive_low}, 2'b00);
        check("intrude_single_done", done_cnt - n, 1);

        $display("[TB] reset after edge 4 of 0xF4");
        run_tx(8'hF4, 1'b0, 1'b0, 1'b1, 1'b0, 0, 4);
        repeat (2) @(negedge clk);
        run_tx(8'hF4, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: serialises one command byte (e.g. 0xED set-LEDs, 0xFF reset) onto the keyboard's bidirectional clock/data lines using the PS/2 request-to-send sequence, then checks the device acknowledge. It sits beside the scancode receiver and shares its synchronised keyboard-clock falling-edge strobe. It drives the open-drain pads only through active-high "pull low" controls.

## Interface

- INHIBIT_CYCLES, default 10000: clk cycles to hold the keyboard clock low (100 µs at 100 MHz); legal range ≥ 2.
- TIMEOUT_CYCLES, default 2000000: watchdog limit in clk cycles from clock release to acknowledge (20 ms at 100 MHz).

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- edge_found  in  1  one-cycle strobe on each synchronised keyboard-clock falling edge.
- kb_data_sync  in  1  synchronised level of the keyboard data line.
- tx_start  in  1  request to send tx_data; accepted only when tx_busy = 0.
- tx_data  in  8  command byte; captured in the cycle tx_start is accepted.
- tx_busy  out  1  high from the cycle after acceptance until return to IDLE; the receiver ignores edges while it is high.
- tx_done  out  1  one-cycle pulse: byte sent and device acknowledged.
- tx_error  out  1  one-cycle pulse: missing acknowledge or watchdog timeout.
- kb_clk_drive_low  out  1  1 = pull keyboard clock low, 0 = release.
- kb_data_drive_low  out  1  1 = pull keyboard data low, 0 = release.

## Operation

- All outputs are registered. Reset values: every output 0, state IDLE, shift register 0, counters 0.
- States: IDLE, INHIBIT, REQ, SEND, ACK, DONE.
- IDLE: lines released. On tx_start, load the 9-bit frame {odd parity, tx_data}, with parity = ~^tx_data. Clear the bit counter, go to INHIBIT.
- INHIBIT: kb_clk_drive_low = 1, data released. The cycle counter runs INHIBIT_CYCLES cycles, then the block goes to REQ.
- REQ (exactly one cycle): kb_clk_drive_low = 1 and kb_data_drive_low = 1 (start bit).
- SEND: clock released, data held low (start bit). The watchdog is cleared on entry. On each edge_found, the bit counter increments:
  - Edges 1–8: drive tx_data bits LSB first. kb_data_drive_low = ~bit.
  - Edge 9: drive the parity bit.
  - Edge 10: release data (stop bit = 1), go to ACK.
- ACK: data released. On edge 11, sample kb_data_sync. A value of 0 goes to DONE with a tx_done pulse. A value of 1 pulses tx_error and goes to DONE.
- DONE (one cycle): tx_busy drops on exit, back to IDLE.
- Watchdog: runs in SEND and ACK. If it reaches TIMEOUT_CYCLES, both lines are released, tx_error pulses, and the block returns to IDLE.
- edge_found is ignored in IDLE, INHIBIT, REQ and DONE.
- tx_start while tx_busy = 1 is ignored; the captured byte is not altered.
- edge_found and watchdog expiry in the same cycle: the edge is processed and the timeout is discarded for that cycle.
- Reset mid-operation releases both lines immediately (asynchronous) and drops tx_busy. No done or error pulse is produced.

## Timing

- Acceptance in cycle T: tx_busy = 1 and kb_clk_drive_low = 1 from T+1.
- The clock is held low for exactly INHIBIT_CYCLES cycles (T+1 … T+INHIBIT_CYCLES).
- REQ occupies cycle T+INHIBIT_CYCLES+1. The clock is released at T+INHIBIT_CYCLES+2.
- Data output changes in the cycle after the corresponding edge_found.
- tx_done or tx_error is asserted in the cycle after edge 11 and lasts one cycle. tx_busy falls one cycle later.
- Back-to-back: a new tx_start is accepted on the first cycle tx_busy = 0.

## Test plan

- INHIBIT_CYCLES = 20, send 0xED with a model device; ack bit = 0:
  - the clock is low exactly 20 cycles, then REQ;
  - the data bits after edges 1–8 are 1,0,1,1,0,1,1,1;
  - parity = 1, stop released;
  - tx_done pulses once and tx_error = 0.
- Send 0x01: parity bit = 0. Send 0xFF: parity bit = 1. Send 0x00: parity bit = 1. Each case ends with tx_done.
- The device returns ack = 1 on edge 11 → tx_error pulses once, tx_done = 0, lines released, IDLE.
- TIMEOUT_CYCLES = 500 and the device never clocks after REQ:
  - tx_error pulses 500 cycles after the clock is released;
  - both drive outputs = 0.
- tx_start pulsed with 0x55 during a 0xED transfer → the 0xED bit sequence is unchanged and only one tx_done is produced.
- Assert rst after edge 4 → both drive outputs and tx_busy = 0 in the same cycle. After release, a new 0xF4 transfer completes normally.
